// File: rtl/vc_arb_pkg.sv
// rtl/vc_arb_pkg.sv - shared FSM, VC index and destination constants for the VC pop arbiter
package vc_arb_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } vc_state_e;

    localparam int VC0 = 0;
    localparam int VC1 = 1;

    localparam int D0 = 0;
    localparam int D1 = 1;

endpackage

// File: rtl/vc_wrr_core.sv
// rtl/vc_wrr_core.sv - weighted round-robin grant decision with VC0 credit and weight registers
module vc_wrr_core #(
    parameter int WEIGHT_W = 2
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                elig0,
    input  logic                elig1,
    input  logic                load_cfg,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    output logic                gnt0,
    output logic                gnt1
);

    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [WEIGHT_W-1:0] weight_q, weight_d;

    always_comb begin
        gnt1     = elig1 && (!elig0 || (credit_q == weight_q));
        gnt0     = elig0 && !gnt1;
        credit_d = credit_q;
        weight_d = weight_q;
        if (load_cfg) begin
            // A zero weight would starve VC0 entirely, so it is promoted to 1.
            weight_d = (cfg_weight == '0) ? WEIGHT_W'(1) : cfg_weight;
            credit_d = '0;
        end else if (gnt1) begin
            credit_d = '0;
        end else if (gnt0 && (credit_q < weight_q)) begin
            credit_d = credit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            credit_q <= '0;
            weight_q <= WEIGHT_W'(1);
        end else begin
            credit_q <= credit_d;
            weight_q <= weight_d;
        end
    end

endmodule

// File: rtl/vc_pop_arbiter.sv
// rtl/vc_pop_arbiter.sv - VC0/VC1 pop scheduler with FSM and demux pipeline; VC_ARB_STATS_EN adds grant counters
module vc_pop_arbiter
    import vc_arb_pkg::*;
#(
    parameter int DATA_SIZE  = 6,
    parameter int BIT_SELECT = 1,
    parameter int WEIGHT_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [WEIGHT_W-1:0]  cfg_weight,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [DATA_SIZE-1:0] vc0_data,
    input  logic [DATA_SIZE-1:0] vc1_data,
    input  logic [1:0]           dest_afull,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 en_pop,
    output logic [DATA_SIZE-1:0] data_demux,
    output logic [1:0]           state,
    output logic                 idle
`ifdef VC_ARB_STATS_EN
    ,
    output logic [7:0]           gnt_cnt0,
    output logic [7:0]           gnt_cnt1
`endif
);

    localparam int DEST_BIT = DATA_SIZE - BIT_SELECT;

    vc_state_e            state_q, state_d;
    logic                 en_pop_q, en_pop_d;
    logic [DATA_SIZE-1:0] data_demux_q, data_demux_d;
    logic                 idle_q, idle_d;
    logic                 run_ok, afull0, afull1, elig0, elig1;
    logic [1:0]           gnt;

    // Eligibility is combinational so a destination flag change acts in the same cycle.
    assign run_ok = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) && !init;
    assign afull0 = vc0_data[DEST_BIT] ? dest_afull[D1] : dest_afull[D0];
    assign afull1 = vc1_data[DEST_BIT] ? dest_afull[D1] : dest_afull[D0];
    assign elig0  = run_ok && !vc0_empty && !afull0;
    assign elig1  = run_ok && !vc1_empty && !afull1;

    vc_wrr_core #(.WEIGHT_W(WEIGHT_W)) u_core (
        .clk        (clk),
        .reset_L    (reset_L),
        .elig0      (elig0),
        .elig1      (elig1),
        .load_cfg   (state_q == ST_INIT),
        .cfg_weight (cfg_weight),
        .gnt0       (gnt[VC0]),
        .gnt1       (gnt[VC1])
    );

    assign pop_vc0    = gnt[VC0];
    assign pop_vc1    = gnt[VC1];
    assign en_pop     = en_pop_q;
    assign data_demux = data_demux_q;
    assign state      = state_q;
    assign idle       = idle_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
            default:  state_d = init ? ST_INIT : ((|gnt) ? ST_ACTIVE : ST_IDLE);
        endcase
        en_pop_d     = |gnt;
        data_demux_d = gnt[VC1] ? vc1_data : (gnt[VC0] ? vc0_data : data_demux_q);
        idle_d       = (state_d == ST_IDLE) && !en_pop_d;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_RESET;
            en_pop_q     <= 1'b0;
            data_demux_q <= '0;
            idle_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_pop_q     <= en_pop_d;
            data_demux_q <= data_demux_d;
            idle_q       <= idle_d;
        end
    end

`ifdef VC_ARB_STATS_EN
    logic [7:0] gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d;

    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (state_d == ST_INIT) begin
            gnt_cnt0_d = '0;
            gnt_cnt1_d = '0;
        end else begin
            if (gnt[VC0] && (gnt_cnt0_q != 8'hFF)) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
            if (gnt[VC1] && (gnt_cnt1_q != 8'hFF)) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb/tb_vc_pop_arbiter.sv - directed self-checking bench for vc_pop_arbiter
module tb_vc_pop_arbiter;

    localparam int DW = 6;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic [WW-1:0] cfg_weight;
    logic          vc0_empty, vc1_empty;
    logic [DW-1:0] vc0_data, vc1_data;
    logic [1:0]    dest_afull;
    logic          pop_vc0, pop_vc1, en_pop, idle;
    logic [DW-1:0] data_demux;
    logic [1:0]    state;
`ifdef VC_ARB_STATS_EN
    logic [7:0]    gnt_cnt0, gnt_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] junk;
    logic          exp_en = 1'b0;
    logic [DW-1:0] exp_dd = '0;

    always #5 clk = ~clk;

    vc_pop_arbiter dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .init       (init),
        .cfg_weight (cfg_weight),
        .vc0_empty  (vc0_empty),
        .vc1_empty  (vc1_empty),
        .vc0_data   (vc0_data),
        .vc1_data   (vc1_data),
        .dest_afull (dest_afull),
        .pop_vc0    (pop_vc0),
        .pop_vc1    (pop_vc1),
        .en_pop     (en_pop),
        .data_demux (data_demux),
        .state      (state),
        .idle       (idle)
`ifdef VC_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = vc0_empty ? '0 : q0[0];
        vc1_data  = vc1_empty ? '0 : q1[0];
    endtask

    // One clock: check pops and pipeline at the falling edge, advance the FIFOs after the rising edge.
    task automatic step(input string tag, input logic e0, input logic e1);
        logic          p0, p1;
        logic [DW-1:0] nx;
        @(negedge clk);
        expect_eq({tag, ".pop0"}, 32'(pop_vc0), 32'(e0));
        expect_eq({tag, ".pop1"}, 32'(pop_vc1), 32'(e1));
        expect_eq({tag, ".en_pop"}, 32'(en_pop), 32'(exp_en));
        expect_eq({tag, ".data"}, 32'(data_demux), 32'(exp_dd));
        nx = e0 ? vc0_data : (e1 ? vc1_data : exp_dd);
        p0 = pop_vc0;
        p1 = pop_vc1;
        @(posedge clk);
        #1;
        exp_en = e0 | e1;
        exp_dd = nx;
        if (p0 && q0.size() != 0) junk = q0.pop_front();
        if (p1 && q1.size() != 0) junk = q1.pop_front();
        refresh();
    endtask

    task automatic expect_state(input string tag, input logic [1:0] st, input logic id);
        expect_eq({tag, ".state"}, 32'(state), 32'(st));
        expect_eq({tag, ".idle"}, 32'(idle), 32'(id));
    endtask

    initial begin
        logic [11:0] rr_pat;
        reset_L    = 1'b0;
        init       = 1'b1;
        cfg_weight = 2'd2;
        dest_afull = 2'b00;
        refresh();
        #2;
        expect_state("rst", 2'd0, 1'b0);
        expect_eq("rst.en_pop", 32'(en_pop), 32'd0);
        expect_eq("rst.data", 32'(data_demux), 32'd0);
        expect_eq("rst.pops", 32'({pop_vc0, pop_vc1}), 32'd0);

        // Reset release, init held for 3 cycles.
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        step("init0", 1'b0, 1'b0);
        expect_state("init0", 2'd1, 1'b0);
        step("init1", 1'b0, 1'b0);
        expect_state("init1", 2'd1, 1'b0);
        step("init2", 1'b0, 1'b0);
        expect_state("init2", 2'd1, 1'b0);
        init = 1'b0;
        step("init3", 1'b0, 1'b0);
        expect_state("init3", 2'd2, 1'b1);

        // Weight 2: 0,0,1 repeating, then only VC1 remains.
        for (int i = 1; i <= 6; i++) begin
            q0.push_back(6'(i));
            q1.push_back(6'(8'h10 + i));
        end
        refresh();
        rr_pat = 12'b001001001111;
        for (int i = 0; i < 12; i++) begin
            step($sformatf("rr%0d", i), !rr_pat[11-i], rr_pat[11-i]);
            expect_state($sformatf("rr%0d", i), 2'd3, 1'b0);
        end
        step("rr_end", 1'b0, 1'b0);
        expect_state("rr_end", 2'd2, 1'b1);
`ifdef VC_ARB_STATS_EN
        expect_eq("rr.cnt0", 32'(gnt_cnt0), 32'd6);
        expect_eq("rr.cnt1", 32'(gnt_cnt1), 32'd6);
`endif

        // Backpressure on D1 blocks the VC0 head until released.
        q0.push_back(6'b100101);
        q0.push_back(6'h03);
        q1.push_back(6'h11);
        q1.push_back(6'h12);
        q1.push_back(6'h13);
        dest_afull = 2'b10;
        refresh();
        step("bp0", 1'b0, 1'b1);
        step("bp1", 1'b0, 1'b1);
        dest_afull = 2'b00;
        step("bp2", 1'b1, 1'b0);
        step("bp3", 1'b1, 1'b0);
        step("bp4", 1'b0, 1'b1);
        step("bp5", 1'b0, 1'b0);

        // Reload with weight 0 (treated as 1), VC0 only.
        cfg_weight = 2'd0;
        init = 1'b1;
        step("w0_init", 1'b0, 1'b0);
        expect_state("w0_init", 2'd1, 1'b0);
        init = 1'b0;
        step("w0_idle", 1'b0, 1'b0);
        expect_state("w0_idle", 2'd2, 1'b1);
        q0.push_back(6'h2A);
        q0.push_back(6'h0B);
        q0.push_back(6'h2C);
        q0.push_back(6'h0D);
        refresh();
        for (int i = 0; i < 4; i++) step($sformatf("w0_%0d", i), 1'b1, 1'b0);
        expect_state("w0_last", 2'd3, 1'b0);
        step("w0_drain", 1'b0, 1'b0);
        expect_state("w0_drain", 2'd2, 1'b1);

        // Credit saturated at weight 1, so VC1 wins first, then strict alternation.
        q0.push_back(6'h01);
        q0.push_back(6'h02);
        q1.push_back(6'h11);
        q1.push_back(6'h12);
        refresh();
        step("w1_0", 1'b0, 1'b1);
        step("w1_1", 1'b1, 1'b0);
        step("w1_2", 1'b0, 1'b1);
        step("w1_3", 1'b1, 1'b0);
        step("w1_4", 1'b0, 1'b0);

        // init mid-stream: in-flight word still delivered, pops stop.
        q0.push_back(6'h05);
        q0.push_back(6'h06);
        q0.push_back(6'h07);
        q0.push_back(6'h08);
        refresh();
        step("mi0", 1'b1, 1'b0);
        init = 1'b1;
        step("mi1", 1'b0, 1'b0);
        expect_state("mi1", 2'd1, 1'b0);
`ifdef VC_ARB_STATS_EN
        expect_eq("mi.cnt0", 32'(gnt_cnt0), 32'd0);
        expect_eq("mi.cnt1", 32'(gnt_cnt1), 32'd0);
`endif
        step("mi2", 1'b0, 1'b0);
        init = 1'b0;
        step("mi3", 1'b0, 1'b0);
        expect_state("mi3", 2'd2, 1'b1);

        // Reset mid-stream: en_pop drops at once, without a clock edge.
        step("mr0", 1'b1, 1'b0);
        expect_eq("mr0.en_pre", 32'(en_pop), 32'd1);
        reset_L = 1'b0;
        #1;
        expect_eq("mr.en_async", 32'(en_pop), 32'd0);
        expect_eq("mr.data_async", 32'(data_demux), 32'd0);
        expect_eq("mr.pop0", 32'(pop_vc0), 32'd0);
        expect_eq("mr.state", 32'(state), 32'd0);
`ifdef VC_ARB_STATS_EN
        expect_eq("mr.cnt0", 32'(gnt_cnt0), 32'd0);
        expect_eq("mr.cnt1", 32'(gnt_cnt1), 32'd0);
`endif
        exp_en = 1'b0;
        exp_dd = '0;
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        step("mr1", 1'b0, 1'b0);
        expect_state("mr1", 2'd1, 1'b0);
        step("mr2", 1'b0, 1'b0);
        expect_state("mr2", 2'd2, 1'b1);
        step("mr3", 1'b1, 1'b0);
        step("mr4", 1'b1, 1'b0);
        step("mr5", 1'b0, 1'b0);
        expect_state("mr5", 2'd2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_pop_arbiter.md
# vc_pop_arbiter

Weighted round-robin pop scheduler between the two virtual-channel FIFOs (VC0, VC1) and the shared destination demux. Each cycle it grants at most one VC whose head word has a non-full destination, pops it, and presents the word to the demux one cycle later on `data_demux`/`en_pop`. It owns the init/idle/active FSM for this stage.

## Interface
- `DATA_SIZE`, 6: word width, including the destination bit.
- `BIT_SELECT`, 1: the destination bit is `data[DATA_SIZE-BIT_SELECT]`. 0 selects D0, 1 selects D1.
- `WEIGHT_W`, 2: width of the VC0 weight and credit counter.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset_L` in 1: asynchronous reset, active-low.
- `init` in 1: request a configuration reload.
- `cfg_weight` in WEIGHT_W: VC0 burst weight. Latched in INIT. A value of 0 is treated as 1.
- `vc0_empty`, `vc1_empty` in 1: source FIFO empty flags.
- `vc0_data`, `vc1_data` in DATA_SIZE: show-ahead head words. Valid while the matching FIFO is not empty.
- `dest_afull` in 2: almost-full flags of destination FIFOs D1:D0.
- `pop_vc0`, `pop_vc1` out 1: combinational pop strobes. They are mutually exclusive.
- `en_pop` out 1: registered. Marks a valid word on `data_demux`.
- `data_demux` out DATA_SIZE: registered word for the demux.
- `state` out 2: current FSM state.
- `idle` out 1: high when the state is IDLE and no word is in flight.

## Operation
- Eligibility, per VC: `eligX = !vcX_empty && !dest_afull[dest(vcX_data)]`.
- Credit counter `credit` (WEIGHT_W bits) counts consecutive VC0 grants.
- VC1 is granted when `elig1 && (!elig0 || credit == weight)`.
- Otherwise VC0 is granted if `elig0`.
- Credit update:
  - On a VC0 grant, `credit` increments and saturates at `weight`.
  - On a VC1 grant, `credit` clears to 0.
  - With no grant, `credit` holds.
- Grants are issued only in IDLE or ACTIVE, and only when `init` is low.
- FSM states and encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- FSM transitions:
  - RESET → INIT unconditionally.
  - INIT: latch `weight = max(cfg_weight,1)` and clear `credit`. Go to IDLE when `init` is low, otherwise stay in INIT.
  - IDLE/ACTIVE with `init` high → INIT. No grant is issued that cycle.
  - IDLE/ACTIVE otherwise: go to ACTIVE if a grant is issued this cycle, else IDLE.
- Pipeline register:
  - `data_demux` is loaded with the granted head word.
  - `en_pop` takes the value `pop_vc0|pop_vc1`.
  - With no grant, `data_demux` is held and `en_pop` is 0.
- Backpressure contract: downstream almost-full must assert with at least 2 free entries, to cover the one in-flight word.
- Reset values: `state`=RESET, `credit`=0, `weight`=1, `en_pop`=0, `data_demux`=0, `idle`=0. Pops are 0 while `reset_L` is low.

## Timing
- Pop at edge N. The same word appears on `data_demux` with `en_pop`=1 after edge N, i.e. it is valid during cycle N+1. Latency is 1 cycle.
- Peak throughput is one word per cycle.
- Dest flag changes act in the same cycle, because eligibility is combinational.
- Reset asserted mid-transfer: the in-flight word is dropped. `en_pop` goes to 0 immediately, asynchronously.
- `init` asserted while a word is in flight: that word is still delivered in the next cycle. No new pops occur while in INIT.
- Both VCs eligible with weight W: the grant pattern repeats as W×VC0 followed by 1×VC1.
- Only one VC eligible: that VC is granted every cycle. If it is VC0, `credit` saturates at W.

## Configuration
- `VC_ARB_STATS_EN` defined:
  - Adds output ports `gnt_cnt0` and `gnt_cnt1`, 8 bits each.
  - Each counts grants per VC and saturates at 255.
  - Reset to 0 by `reset_L` and on entry to INIT.
- `VC_ARB_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `vc_arb_pkg` holds:
  - the FSM state typedef and encodings;
  - VC index constants VC0=0, VC1=1;
  - destination constants D0=0, D1=1.
- Sub-module `vc_wrr_core` holds the credit and weight registers and the grant decision. Its inputs are `elig0`, `elig1`, `load_cfg`, `cfg_weight`; its outputs are `gnt0`, `gnt1`.
- The top level holds the FSM, eligibility logic and pipeline register.

## Test plan
- Reset and init:
  - Stimulus: `reset_L` low, then release with `init`=1 for 3 cycles, then `init`=0.
  - Required: `state` goes 0 → 1 (held) → 2; outputs stay 0; no pops.
- Weighted RR:
  - Stimulus: `cfg_weight`=2, both FIFOs hold 6 words, all dest bits 0, `dest_afull`=00.
  - Required: pop pattern 0,0,1,0,0,1,…; `en_pop` runs one cycle behind each pop with matching data.
- Backpressure:
  - Stimulus: VC0 head word 6'b100101 (dest D1), `dest_afull`=10.
  - Required: VC0 is not popped while VC1 (dest D0) is served. After `dest_afull`=00, VC0 is popped in that same cycle.
- Weight zero and empty:
  - Stimulus: `cfg_weight`=0, only VC0 holds data.
  - Required: VC0 is popped every cycle. Once drained, `state`=IDLE and `idle`=1 one cycle after the last `en_pop`.
- Mid-run events:
  - Stimulus: `init` pulsed during a stream, then `reset_L` pulsed low during a later stream.
  - Required for `init`: the in-flight word is delivered and pops stop.
  - Required for `reset_L`: `en_pop` drops to 0 asynchronously.
  - With `VC_ARB_STATS_EN`, both counters read 0 after either event.
